// File: rtl/stopwatch_counter.sv
// stopwatch_counter: divides clk into 1 Hz / 2 Hz ticks and keeps MM:SS as four BCD digits,
// with pause/resume and a per-field manual adjust mode stepped at 2 Hz.
module stopwatch_counter #(
    parameter int unsigned ONE_HZ_DIV = 100_000_000,
    parameter int unsigned TWO_HZ_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       resett,
    input  logic       pause,
    input  logic       select,
    input  logic [1:0] adj,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       paused,
    output logic       adjusting,
    output logic       blink
);

    localparam int unsigned DIV1_W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
    localparam int unsigned DIV2_W = (TWO_HZ_DIV > 1) ? $clog2(TWO_HZ_DIV) : 1;
    localparam logic [DIV1_W-1:0] DIV1_MAX = DIV1_W'(ONE_HZ_DIV - 1);
    localparam logic [DIV2_W-1:0] DIV2_MAX = DIV2_W'(TWO_HZ_DIV - 1);

    logic [DIV1_W-1:0] div1_q, div1_d;
    logic [DIV2_W-1:0] div2_q, div2_d;
    logic [3:0]        min1_q, min1_d, min0_q, min0_d;
    logic [3:0]        sec1_q, sec1_d, sec0_q, sec0_d;
    logic              paused_q, paused_d;
    logic              adjusting_q, adjusting_d;
    logic              blink_q, blink_d;
    logic              tick1_c, tick2_c;
    logic              sec_wrap_c;

    // One step of a 00..59 BCD field, wrapping in both directions; returns {tens, units}.
    function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] units,
                                            input logic down);
        logic [3:0] t;
        logic [3:0] u;
        t = tens;
        u = units;
        if (!down) begin
            if (units == 4'd9) begin
                u = 4'd0;
                t = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
            end else begin
                u = units + 4'd1;
            end
        end else begin
            if (units == 4'd0) begin
                u = 4'd9;
                t = (tens == 4'd0) ? 4'd5 : tens - 4'd1;
            end else begin
                u = units - 4'd1;
            end
        end
        return {t, u};
    endfunction

    // Next-state: free-running dividers, time/adjust update, pause toggle, blink.
    always_comb begin
        div1_d      = (div1_q == DIV1_MAX) ? '0 : div1_q + DIV1_W'(1);
        div2_d      = (div2_q == DIV2_MAX) ? '0 : div2_q + DIV2_W'(1);
        tick1_c     = (div1_q == DIV1_MAX);
        tick2_c     = (div2_q == DIV2_MAX);
        sec_wrap_c  = (sec1_q == 4'd5) && (sec0_q == 4'd9);
        min1_d      = min1_q;
        min0_d      = min0_q;
        sec1_d      = sec1_q;
        sec0_d      = sec0_q;
        paused_d    = paused_q;
        adjusting_d = adj[0];
        blink_d     = blink_q;

        if (adj[0]) begin
            // Adjust: only the selected field moves, never carries, ignores pause.
            if (tick2_c) begin
                if (select) begin
                    {sec1_d, sec0_d} = bcd_step(sec1_q, sec0_q, adj[1]);
                end else begin
                    {min1_d, min0_d} = bcd_step(min1_q, min0_q, adj[1]);
                end
            end
        end else if (tick1_c && !paused_q) begin
            {sec1_d, sec0_d} = bcd_step(sec1_q, sec0_q, 1'b0);
            if (sec_wrap_c) begin
                {min1_d, min0_d} = bcd_step(min1_q, min0_q, 1'b0);
            end
        end

        if (pause) begin
            paused_d = ~paused_q;
        end
        if (tick2_c) begin
            blink_d = ~blink_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge resett) begin
        if (resett) begin
            div1_q      <= '0;
            div2_q      <= '0;
            min1_q      <= 4'd0;
            min0_q      <= 4'd0;
            sec1_q      <= 4'd0;
            sec0_q      <= 4'd0;
            paused_q    <= 1'b0;
            adjusting_q <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            div1_q      <= div1_d;
            div2_q      <= div2_d;
            min1_q      <= min1_d;
            min0_q      <= min0_d;
            sec1_q      <= sec1_d;
            sec0_q      <= sec0_d;
            paused_q    <= paused_d;
            adjusting_q <= adjusting_d;
            blink_q     <= blink_d;
        end
    end

    assign min1      = min1_q;
    assign min0      = min0_q;
    assign sec1      = sec1_q;
    assign sec0      = sec0_q;
    assign paused    = paused_q;
    assign adjusting = adjusting_q;
    assign blink     = blink_q;

endmodule
